// File: rtl/months.sv
// Month stage of the calendar chain: keeps month 1..12, reports the length of
// the current month and pulses done_month once per December-to-January rollover.
module months (
    input  logic       clk,
    input  logic       rst,
    input  logic       display,
    input  logic       setup_month,
    input  logic       inc_dec_month,
    input  logic       tick,
    input  logic       done_day,
    input  logic [6:0] year,
    output logic [3:0] month,
    output logic [4:0] days_max,
    output logic       done_month
);

    logic [3:0] month_next;
    logic       roll;
    logic       roll_p0;

    function automatic logic [4:0] month_len(input logic [3:0] m, input logic leap);
        case (m)
            4'd2:                    month_len = leap ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11: month_len = 5'd30;
            default:                 month_len = 5'd31;
        endcase
    endfunction

    // Only run mode can roll over; setup wraps never raise roll.
    always_comb begin
        month_next = month;
        roll       = 1'b0;
        if (month == 4'd0 || month > 4'd12) begin
            month_next = 4'd1;
        end else if (!display) begin
            if (done_day) begin
                if (month == 4'd12) begin
                    month_next = 4'd1;
                    roll       = 1'b1;
                end else begin
                    month_next = month + 4'd1;
                end
            end
        end else if (!setup_month && tick) begin
            if (inc_dec_month)
                month_next = (month == 4'd12) ? 4'd1 : month + 4'd1;
            else
                month_next = (month == 4'd1) ? 4'd12 : month - 4'd1;
        end
    end

    // Stage p0: month state and the rollover event seen at this rising edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            month   <= 4'd1;
            roll_p0 <= 1'b0;
        end else begin
            month   <= month_next;
            roll_p0 <= roll;
        end
    end

    // Stage p1: half-cycle retiming so done_month straddles the next rising edge
    always_ff @(negedge clk or posedge rst) begin
        if (rst)
            done_month <= 1'b0;
        else
            done_month <= roll_p0;
    end

    assign days_max = month_len(month, (year[1:0] == 2'b00));

endmodule

// File: tb/tb_months.sv
// Directed bench for the month stage with a behavioural calendar model checked
// after every clock edge, plus hand-computed literal expectations.
module tb_months;

    logic       clk = 1'b0;
    logic       rst;
    logic       display;
    logic       setup_month;
    logic       inc_dec_month;
    logic       tick;
    logic       done_day;
    logic [6:0] year;
    logic [3:0] month;
    logic [4:0] days_max;
    logic       done_month;

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    bit chk_en = 1'b0;

    int exp_month = 1;
    bit exp_roll  = 1'b0;
    bit exp_done  = 1'b0;

    months dut (
        .clk           (clk),
        .rst           (rst),
        .display       (display),
        .setup_month   (setup_month),
        .inc_dec_month (inc_dec_month),
        .tick          (tick),
        .done_day      (done_day),
        .year          (year),
        .month         (month),
        .days_max      (days_max),
        .done_month    (done_month)
    );

    always #5 clk = ~clk;

    // Calendar model: month as an integer 1..12, lengths from a table.
    function automatic int model_days(input int m, input int y);
        int len [12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (m == 2 && (y % 4) == 0) return 29;
        return len[m - 1];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_month = 1;
            exp_roll  = 1'b0;
        end else begin
            exp_roll = 1'b0;
            if (!display) begin
                if (done_day) begin
                    exp_roll  = (exp_month == 12);
                    exp_month = (exp_month % 12) + 1;
                end
            end else if (!setup_month && tick) begin
                if (inc_dec_month) exp_month = (exp_month % 12) + 1;
                else               exp_month = ((exp_month + 10) % 12) + 1;
            end
        end
    end

    always @(negedge clk or posedge rst) begin
        if (rst) exp_done = 1'b0;
        else     exp_done = exp_roll;
    end

    always @(posedge done_month) n_done++;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic compare(input string where);
        check({where, "_month"}, int'(month), exp_month);
        check({where, "_days"}, int'(days_max), model_days(exp_month, int'(year)));
        check({where, "_done"}, int'(done_month), int'(exp_done));
    endtask

    initial forever begin
        @(posedge clk); #1;
        if (chk_en) compare("pos");
    end

    initial forever begin
        @(negedge clk); #1;
        if (chk_en) compare("neg");
    end

    // Let one rising edge pass; inputs change 2 time units after it.
    task automatic cyc();
        @(posedge clk); #2;
    endtask

    task automatic pulse_day();
        done_day = 1'b1;
        cyc();
        done_day = 1'b0;
    endtask

    task automatic set_tick(input logic dir);
        display = 1'b1; setup_month = 1'b0; inc_dec_month = dir; tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    initial begin
        rst = 1'b1; display = 1'b0; setup_month = 1'b1; inc_dec_month = 1'b1;
        tick = 1'b0; done_day = 1'b0; year = 7'd24;
        repeat (2) @(posedge clk);
        #2;
        chk_en = 1'b1;
        check("rst_month", int'(month), 1);
        check("rst_days", int'(days_max), 31);
        check("rst_done", int'(done_month), 0);
        rst = 1'b0;
        cyc();
        check("idle_month", int'(month), 1);

        // Twelve run-mode day rollovers: 2..12 then back to 1, one done pulse.
        n_done = 0;
        for (int i = 1; i <= 12; i++) begin
            pulse_day();
            check("adv_month", int'(month), (i == 12) ? 1 : i + 1);
        end
        repeat (3) cyc();
        check("adv_pulses", n_done, 1);

        // Setup wrap down and up, no rollover pulse.
        n_done = 0;
        set_tick(1'b0);
        check("setup_dec_wrap", int'(month), 12);
        @(negedge clk); #1;
        check("setup_wrap_done", int'(done_month), 0);
        @(posedge clk); #2;
        set_tick(1'b1);
        check("setup_inc_wrap", int'(month), 1);
        repeat (2) cyc();
        check("setup_pulses", n_done, 0);

        // Run rollover timing from month 12.
        set_tick(1'b0);
        display = 1'b0; setup_month = 1'b1;
        pulse_day();
        check("roll_month", int'(month), 1);
        check("roll_done_early", int'(done_month), 0);
        @(negedge clk); #1;
        check("roll_done_high", int'(done_month), 1);
        @(posedge clk); #1;
        check("roll_done_stable", int'(done_month), 1);
        @(negedge clk); #1;
        check("roll_done_low", int'(done_month), 0);
        @(posedge clk); #2;

        // Leap-year rule and month lengths.
        pulse_day();
        year = 7'd24; #1 check("feb_24", int'(days_max), 29);
        year = 7'd25; #1 check("feb_25", int'(days_max), 28);
        year = 7'd0;  #1 check("feb_00", int'(days_max), 29);
        @(posedge clk); #2;
        year = 7'd24;
        repeat (2) pulse_day();
        check("apr_days", int'(days_max), 30);
        repeat (3) pulse_day();
        check("jul_days", int'(days_max), 31);

        // Ignore rules.
        display = 1'b1; setup_month = 1'b1; done_day = 1'b1;
        cyc();
        done_day = 1'b0;
        check("ign_day_in_setup", int'(month), 7);
        display = 1'b0; setup_month = 1'b0; tick = 1'b1;
        cyc();
        tick = 1'b0;
        check("ign_tick_in_run", int'(month), 7);
        display = 1'b1; setup_month = 1'b1; tick = 1'b1;
        cyc();
        tick = 1'b0;
        check("ign_tick_unselected", int'(month), 7);
        display = 1'b1; setup_month = 1'b0; inc_dec_month = 1'b1; tick = 1'b1; done_day = 1'b1;
        cyc();
        tick = 1'b0; done_day = 1'b0;
        check("simul_setup_wins", int'(month), 8);

        // Reset mid-pulse with month 12.
        repeat (4) set_tick(1'b1);
        check("pre_rst_month", int'(month), 12);
        display = 1'b0; setup_month = 1'b1;
        pulse_day();
        set_tick(1'b0);
        check("mid_month", int'(month), 12);
        check("mid_done", int'(done_month), 1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_month", int'(month), 1);
        check("async_rst_done", int'(done_month), 0);
        check("async_rst_days", int'(days_max), 31);
        display = 1'b1; setup_month = 1'b0; inc_dec_month = 1'b0; tick = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hold_month", int'(month), 1);
        check("rst_hold_done", int'(done_month), 0);
        #1 rst = 1'b0;
        #2 check("post_rst_no_change", int'(month), 1);
        @(posedge clk); #2;
        tick = 1'b0;
        check("first_edge_after_rst", int'(month), 12);
        repeat (2) cyc();

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule

// File: doc/months.md
MONTHS -- requirements
Module: months

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning); the clock and reset are `clk` and `rst`, with one clock and an asynchronous, active-high reset.
- `clk` -- input, 1 -- the single system clock; all state is on it.
- `rst` -- input, 1 -- asynchronous, active-high reset.
- `display` -- input, 1 -- 0 = run mode (calendar advances), 1 = setup mode.
- `setup_month` -- input, 1 -- active-low month-edit select; only meaningful when `display` = 1.
- `inc_dec_month` -- input, 1 -- setup direction: 1 = increment, 0 = decrement.
- `tick` -- input, 1 -- single-cycle setup step strobe.
- `done_day` -- input, 1 -- day-rollover pulse from the upstream days stage.
- `year` -- input, 7 -- current year, 0..99, from the downstream years stage; used for the leap-year rule.
- `month` -- output, 4 -- current month, 1..12.
- `days_max` -- output, 5 -- number of days in the current month, fed back to the days stage.
- `done_month` -- output, 1 -- month-rollover pulse consumed by the years stage.

Function
REQ-002 `month` SHALL be a 4-bit register updated on the rising edge of `clk`, and SHALL always hold a value in 1..12.
REQ-003 Run mode (`display` = 0): when `done_day` = 1 at a rising edge:
- `month` < 12: increment `month` by 1.
- `month` = 12: load 1 and raise the internal rollover flag for that cycle.
REQ-004 Run mode with `done_day` = 0: `month` SHALL hold.
REQ-005 Run mode: `tick`, `setup_month` and `inc_dec_month` SHALL be ignored.
REQ-006 Setup mode (`display` = 1, `setup_month` = 0, `tick` = 1):
- `inc_dec_month` = 1: 12 wraps to 1; otherwise increment by 1.
- `inc_dec_month` = 0: 1 wraps to 12; otherwise decrement by 1.
REQ-007 Setup mode SHALL NOT raise the rollover flag, including on a setup wrap.
REQ-008 Setup mode with `setup_month` = 1 or `tick` = 0: `month` SHALL hold.
REQ-009 In setup mode, `done_day` SHALL be ignored.
REQ-010 The internal rollover flag SHALL be combinational and captured into the `done_month` register on the falling edge of `clk`.
REQ-011 As a result of REQ-010, `done_month` SHALL be high for exactly one full clock period, stable across the next rising edge, for each 12-to-1 run-mode rollover.
REQ-012 `days_max` SHALL be combinational from the `month` register and `year`:
- months 1, 3, 5, 7, 8, 10, 12: 31.
- months 4, 6, 9, 11: 30.
- month 2: 29 when `year[1:0]` = 0 (year 2000+`year`; year 0 is a leap year), else 28.
REQ-013 If `month` ever holds 0 or 13..15, the next rising edge SHALL load 1 and `days_max` SHALL read 31 in the meantime.
REQ-014 Mode switching: a `display` change takes effect at the next rising edge, and no spurious `done_month` SHALL result from the switch.
REQ-015 Simultaneous `done_day` and `tick` SHALL be resolved by `display` alone; there is no queuing of the losing event.

Reset
REQ-016 While `rst` = 1, asynchronously and independent of `clk`:
- `month` = 1.
- `done_month` = 0.
- `days_max` = 31.
REQ-017 Reset asserted mid-pulse SHALL clear `done_month` immediately.
REQ-018 After reset release, the first state change SHALL occur no earlier than the first rising edge of `clk` with `rst` = 0.

Verification
REQ-019 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Run rollover: `display`=0, `month`=12, pulse `done_day` one cycle -> `month`=1 after the edge; `done_month`=1 from the following falling edge for exactly one period.
- Run advance: `month`=1, twelve `done_day` pulses -> `month` 2..12 then 1; exactly one `done_month` pulse.
- Setup wrap: `display`=1, `setup_month`=0, `inc_dec_month`=0, `month`=1, one `tick` -> `month`=12, `done_month` stays 0. Then `inc_dec_month`=1, one `tick` -> `month`=1.
- Leap rule: `month`=2 with `year`=24 -> `days_max`=29; `year`=25 -> 28; `year`=0 -> 29. `month`=4 -> 30; `month`=7 -> 31.
- Ignore rules: `display`=1 with a `done_day` pulse -> `month` unchanged. `display`=0 with `tick`=1 and `done_day`=0 -> `month` unchanged. `display`=1, `setup_month`=1 with `tick` -> `month` unchanged.
- Reset: assert `rst` between edges while `done_month`=1 and `month`=12 -> `done_month`=0 and `month`=1 at once; hold for 3 cycles -> no change.
